// File: rtl/turn_controller_if.sv
// Board sequencer bus: cursor/place request in, board and game status out to the renderer.
interface turn_controller_if;
  logic        place;
  logic [1:0]  cur_x;
  logic [1:0]  cur_y;
  logic [15:0] xcells;
  logic [15:0] ocells;
  logic        turn;
  logic [1:0]  winner;
  logic [15:0] line;
  logic [3:0]  time_left;
  logic        timeout;
  logic        illegal;

  modport master (
    output place, cur_x, cur_y,
    input  xcells, ocells, turn, winner, line, time_left, timeout, illegal
  );

  modport slave (
    input  place, cur_x, cur_y,
    output xcells, ocells, turn, winner, line, time_left, timeout, illegal
  );
endinterface

// File: rtl/turn_controller.sv
// 4x4 tic-tac-toe turn sequencer: mark visible 1 edge after place, winner/turn 2 edges after; no backpressure.
// Define AUTO_MOVE_EN to auto-place on a pseudo-random free cell at timeout instead of forfeiting the turn.
module turn_controller #(
  parameter int TICKS_PER_SEC = 25_000_000,
  parameter int TURN_SECONDS  = 10
) (
  input  logic             clk,
  input  logic             reset,
  turn_controller_if.slave bus
);

  localparam int             PW        = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]  PMAX      = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]     TIME_INIT = 4'(TURN_SECONDS);

  typedef enum logic [1:0] {S_PLAY, S_AUTO, S_CHECK, S_DONE} state_t;

  state_t         r_state;
  logic [15:0]    r_x;
  logic [15:0]    r_o;
  logic           r_turn;
  logic [1:0]     r_winner;
  logic [15:0]    r_line;
  logic [3:0]     r_time;
  logic           r_timeout;
  logic           r_illegal;
  logic [PW-1:0]  r_presc;
  logic [3:0]     r_lfsr;
`ifdef AUTO_MOVE_EN
  logic [3:0]     r_ptr;
`endif

  logic [15:0]    w_occ;
  logic [3:0]     w_idx;
  logic           w_free;
  logic           w_wrap;
  logic [15:0]    w_mover;
  logic [15:0]    w_line;

  assign w_occ   = r_x | r_o;
  assign w_idx   = {bus.cur_y, bus.cur_x};
  assign w_free  = ~w_occ[w_idx];
  assign w_wrap  = (r_presc == PMAX);
  assign w_mover = r_turn ? r_o : r_x;

  // Only the player who just moved can have completed a line.
  always_comb begin
    w_line = '0;
    for (int i = 0; i < 4; i++) begin
      if ((w_mover & (16'h000F << (4 * i))) == (16'h000F << (4 * i)))
        w_line = w_line | (16'h000F << (4 * i));
      if ((w_mover & (16'h1111 << i)) == (16'h1111 << i))
        w_line = w_line | (16'h1111 << i);
    end
    if ((w_mover & 16'h8421) == 16'h8421) w_line = w_line | 16'h8421;
    if ((w_mover & 16'h1248) == 16'h1248) w_line = w_line | 16'h1248;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_PLAY;
      r_x       <= '0;
      r_o       <= '0;
      r_turn    <= 1'b0;
      r_winner  <= 2'b00;
      r_line    <= '0;
      r_time    <= TIME_INIT;
      r_timeout <= 1'b0;
      r_illegal <= 1'b0;
      r_presc   <= '0;
      r_lfsr    <= 4'b1001;
`ifdef AUTO_MOVE_EN
      r_ptr     <= '0;
`endif
    end else begin
      r_lfsr    <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
      r_timeout <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_PLAY: begin
          // A place request in the same cycle as expiry takes precedence.
          if (bus.place) begin
            if (w_free) begin
              if (r_turn) r_o[w_idx] <= 1'b1;
              else        r_x[w_idx] <= 1'b1;
              r_state <= S_CHECK;
            end else begin
              r_illegal <= 1'b1;
            end
          end else if (w_wrap) begin
            r_presc <= '0;
            if (r_time == 4'd1) begin
              r_timeout <= 1'b1;
`ifdef AUTO_MOVE_EN
              r_time  <= 4'd0;
              r_ptr   <= r_lfsr;
              r_state <= S_AUTO;
`else
              r_turn  <= ~r_turn;
              r_time  <= TIME_INIT;
`endif
            end else begin
              r_time <= r_time - 4'd1;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
`ifdef AUTO_MOVE_EN
        S_AUTO: begin
          if (!w_occ[r_ptr]) begin
            if (r_turn) r_o[r_ptr] <= 1'b1;
            else        r_x[r_ptr] <= 1'b1;
            r_state <= S_CHECK;
          end else begin
            r_ptr <= r_ptr + 4'd1;
          end
        end
`endif
        S_CHECK: begin
          if (w_line != 16'h0000) begin
            r_winner <= r_turn ? 2'b10 : 2'b01;
            r_line   <= w_line;
            r_state  <= S_DONE;
          end else if (&w_occ) begin
            r_winner <= 2'b11;
            r_line   <= '0;
            r_state  <= S_DONE;
          end else begin
            r_turn  <= ~r_turn;
            r_time  <= TIME_INIT;
            r_presc <= '0;
            r_state <= S_PLAY;
          end
        end
        S_DONE: begin
        end
        default: r_state <= S_PLAY;
      endcase
    end
  end

  assign bus.xcells    = r_x;
  assign bus.ocells    = r_o;
  assign bus.turn      = r_turn;
  assign bus.winner    = r_winner;
  assign bus.line      = r_line;
  assign bus.time_left = r_time;
  assign bus.timeout   = r_timeout;
  assign bus.illegal   = r_illegal;

endmodule
